// File: rtl/kernel_window_generator_if.sv
// kernel_window_generator_if: pixel-in / 3x3-window-out handshake bundle.
interface kernel_window_generator_if #(parameter int DATA_WIDTH = 8);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [9*DATA_WIDTH-1:0] kernel;
    logic                    out_last;
    modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, kernel, out_last);
    modport slave  (input in_valid, data_in, out_ready, output in_ready, out_valid, kernel, out_last);
endinterface

// File: rtl/kernel_window_generator.sv
// kernel_window_generator: raster pixels in, 3x3 neighbourhood windows out.
// Define KWIN_LAST_EN to flag the final window of each frame on out_last.
module kernel_window_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48
) (
    input logic clk,
    input logic rst,
    kernel_window_generator_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [8:0][DATA_WIDTH-1:0] win;
    logic out_valid, accept, emit, col_end, row_end;
    assign bus.in_ready = bus.out_ready || !out_valid;
    assign accept = bus.in_valid && bus.in_ready;
    assign col_end = col == CW'(IMG_WIDTH - 1);
    assign row_end = row == RW'(IMG_HEIGHT - 1);
    assign emit = accept && row >= RW'(2) && col >= CW'(2);
    assign bus.out_valid = out_valid;
    assign bus.kernel = win;
    // Window shifts left; column 2 takes {two lines up, one line up, incoming pixel}
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            out_valid <= 1'b0;
            win <= '0;
        end else begin
            if (accept) begin
                col <= col_end ? '0 : col + 1'b1;
                row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
                win <= {bus.data_in, win[8:7], lb0[col], win[5:4], lb1[col], win[2:1]};
            end
            out_valid <= accept ? emit : out_valid && !bus.out_ready;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= bus.data_in;
            lb1[col] <= lb0[col];
        end
    end
`ifdef KWIN_LAST_EN
    logic last;
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b0;
        else last <= accept ? emit && row_end && col_end : last && !bus.out_ready;
    end
    assign bus.out_last = last;
`else
    assign bus.out_last = 1'b0;
`endif
endmodule

// File: tb/tb_kernel_window_generator.sv
// tb_kernel_window_generator: scoreboard bench for 4x4 and 64x48 window generators.
module tb_kernel_window_generator;
    typedef struct {logic [71:0] k; logic l;} exp_t;
`ifdef KWIN_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    kernel_window_generator_if #(.DATA_WIDTH(8)) bs();
    kernel_window_generator_if #(.DATA_WIDTH(8)) bb();
    kernel_window_generator #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4))
        dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
    kernel_window_generator #(.DATA_WIDTH(8), .IMG_WIDTH(64), .IMG_HEIGHT(48))
        dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
    int checks = 0, errors = 0;
    exp_t sq[$], bq[$];
    logic [71:0] s_obs[$];
    logic [7:0] simg [4][4];
    logic [7:0] bimg [48][64];
    int sr = 0, sc = 0, br = 0, bc = 0, s_nlast = 0, b_nwin = 0;
    exp_t se, be;
    bit bdone;

    function automatic logic [71:0] make_win(int off);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'((i / 3) * 4 + i % 3 + off);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst && bs.out_valid && bs.out_ready) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_window kernel=%h", bs.kernel);
            end else begin
                se = sq.pop_front();
                if (bs.kernel !== se.k || bs.out_last !== se.l) begin
                    errors++;
                    $display("FAIL small_window got=%h/%b exp=%h/%b", bs.kernel, bs.out_last, se.k, se.l);
                end
            end
            s_obs.push_back(bs.kernel);
            if (bs.out_last) s_nlast++;
        end
        if (!rst && bb.out_valid && bb.out_ready) begin
            checks++;
            b_nwin++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL big_unexpected_window kernel=%h", bb.kernel);
            end else begin
                be = bq.pop_front();
                if (bb.kernel !== be.k || bb.out_last !== be.l) begin
                    errors++;
                    $display("FAIL big_window n=%0d got=%h/%b exp=%h/%b", b_nwin, bb.kernel, bb.out_last, be.k, be.l);
                end
            end
        end
    end

    task automatic s_push(input logic [7:0] p);
        exp_t e;
        simg[sr][sc] = p;
        if (sr >= 2 && sc >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) e.k[(r*3+c)*8 +: 8] = simg[sr-2+r][sc-2+c];
            e.l = LAST_EN && sr == 3 && sc == 3;
            sq.push_back(e);
        end
        sc = (sc == 3) ? 0 : sc + 1;
        if (sc == 0) sr = (sr == 3) ? 0 : sr + 1;
    endtask

    task automatic b_push(input logic [7:0] p);
        exp_t e;
        bimg[br][bc] = p;
        if (br >= 2 && bc >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) e.k[(r*3+c)*8 +: 8] = bimg[br-2+r][bc-2+c];
            e.l = LAST_EN && br == 47 && bc == 63;
            bq.push_back(e);
        end
        bc = (bc == 63) ? 0 : bc + 1;
        if (bc == 0) br = (br == 47) ? 0 : br + 1;
    endtask

    task automatic s_send(input logic [7:0] p);
        bit acc;
        bs.in_valid = 1'b1;
        bs.data_in = p;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            acc = bs.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                s_push(p);
                break;
            end
            if (t == 100) begin
                checks++;
                errors++;
                $display("FAIL small_send_timeout pixel=%0d", p);
                break;
            end
        end
        bs.in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] p);
        bit acc;
        bb.in_valid = 1'b1;
        bb.data_in = p;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            acc = bb.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                b_push(p);
                break;
            end
            if (t == 100) begin
                checks++;
                errors++;
                $display("FAIL big_send_timeout pixel=%0d", p);
                break;
            end
        end
        bb.in_valid = 1'b0;
    endtask

    task automatic s_frame(input int base);
        for (int p = 0; p < 16; p++) s_send(8'(base + p));
    endtask

    task automatic s_reset_model();
        sq.delete();
        s_obs.delete();
        sr = 0;
        sc = 0;
        s_nlast = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_reset_model();
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int n);
        checks++;
        if (s_obs.size() != n || sq.size() != 0) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d pending=%0d", name, s_obs.size(), n, sq.size());
        end else begin
            checks++;
            if (s_obs[0] !== make_win(0)) begin
                errors++;
                $display("FAIL %s_first got=%h exp=%h", name, s_obs[0], make_win(0));
            end
            checks++;
            if (s_obs[3] !== make_win(5)) begin
                errors++;
                $display("FAIL %s_last got=%h exp=%h", name, s_obs[3], make_win(5));
            end
        end
        checks++;
        if (s_nlast != (LAST_EN ? n / 4 : 0)) begin
            errors++;
            $display("FAIL %s_out_last_count got=%0d exp=%0d", name, s_nlast, LAST_EN ? n / 4 : 0);
        end
    endtask

    task automatic test_reset();
        bs.in_valid = 1'b0; bs.data_in = '0; bs.out_ready = 1'b0;
        bb.in_valid = 1'b0; bb.data_in = '0; bb.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bs.out_valid !== 1'b0 || bs.out_last !== 1'b0 || bs.kernel !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b last=%b kernel=%h exp 0", bs.out_valid, bs.out_last, bs.kernel);
        end
        checks++;
        if (bs.in_ready !== 1'b1 || bb.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b/%b exp=1", bs.in_ready, bb.in_ready);
        end
        checks++;
        if (bb.out_valid !== 1'b0 || bb.kernel !== '0) begin
            errors++;
            $display("FAIL reset_big_outputs valid=%b kernel=%h exp 0", bb.out_valid, bb.kernel);
        end
        s_reset_model();
    endtask

    task automatic test_frame();
        do_reset();
        bs.out_ready = 1'b1;
        s_frame(0);
        drain();
        check_frame("frame", 4);
    endtask

    task automatic test_stall();
        logic [71:0] k0;
        do_reset();
        bs.out_ready = 1'b0;
        fork
            s_frame(0);
            begin
                for (int t = 0; t < 200 && !bs.out_valid; t++) @(negedge clk);
                checks++;
                if (!bs.out_valid) begin
                    errors++;
                    $display("FAIL stall_no_window got=0 exp=1");
                end
                k0 = bs.kernel;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (bs.out_valid !== 1'b1 || bs.kernel !== k0 || bs.in_ready !== 1'b0 || bs.out_last !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold valid=%b in_ready=%b kernel=%h exp=%h", bs.out_valid, bs.in_ready, bs.kernel, k0);
                    end
                end
                @(posedge clk);
                #1;
                bs.out_ready = 1'b1;
            end
        join
        drain();
        check_frame("stall", 4);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bs.out_ready = 1'b1;
        s_frame(0);
        s_frame(100);
        drain();
        check_frame("b2b", 8);
        checks++;
        if (s_obs.size() != 8 || s_obs[4] !== make_win(100)) begin
            errors++;
            $display("FAIL b2b_frame2_first got=%h exp=%h", s_obs.size() > 4 ? s_obs[4] : 72'h0, make_win(100));
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        bs.out_ready = 1'b1;
        for (int p = 0; p < 7; p++) s_send(8'(200 + p));
        do_reset();
        @(negedge clk);
        checks++;
        if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state in_ready=%b valid=%b exp 1/0", bs.in_ready, bs.out_valid);
        end
        @(posedge clk);
        #1;
        s_frame(0);
        drain();
        check_frame("midreset", 4);
    endtask

    task automatic test_random_frame();
        bdone = 1'b0;
        bq.delete();
        b_nwin = 0;
        fork
            begin
                for (int i = 0; i < 64 * 48; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    b_send(8'($urandom));
                end
                bdone = 1'b1;
            end
            while (!bdone) begin
                bb.out_ready = $urandom_range(0, 3) != 0;
                @(posedge clk);
                #1;
            end
        join
        bb.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (b_nwin != 2852 || bq.size() != 0) begin
            errors++;
            $display("FAIL random_count got=%0d exp=2852 pending=%0d", b_nwin, bq.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_window_generator.md
KERNEL_WINDOW_GENERATOR -- requirements
Module: kernel_window_generator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 64, pixels per line (min 3).
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 48, lines per frame (min 3).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH, raster-order pixel.
REQ-009 The block SHALL have port out_valid, output, 1, window valid to the 3x3 operator.
REQ-010 The block SHALL have port out_ready, input, 1, downstream operator accepts the window.
REQ-011 The block SHALL have port kernel, output, 9*DATA_WIDTH, packed 3x3 window.
REQ-012 The block SHALL have port out_last, output, 1, marks the final window of a frame.

Function
REQ-013 kernel[i*DATA_WIDTH +: DATA_WIDTH] SHALL hold element i = row*3+col; row 0 is the oldest (top) line, col 0 the leftmost pixel.
REQ-014 A pixel SHALL be accepted only when in_valid && in_ready.
REQ-015 in_ready SHALL equal out_ready || !out_valid (single output register, no skid).
REQ-016 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) SHALL advance on each accepted pixel; the column wraps to 0 and increments the row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (next frame).
REQ-017 Two line buffers of IMG_WIDTH entries SHALL store the previous two lines; each column entry SHALL be read and written in the same accept cycle.
REQ-018 A 3x3 shift window SHALL shift left on each accepted pixel, loading column 2 with {line_buf1, line_buf0, data_in} for rows 0,1,2.
REQ-019 out_valid SHALL assert in the cycle after accepting the pixel at row>=2 and col>=2, with kernel holding that window; no windows are produced for other positions.
REQ-020 Each frame SHALL yield exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
REQ-021 While out_valid && !out_ready, kernel, out_valid and out_last SHALL hold stable and no pixel SHALL be accepted.
REQ-022 out_valid SHALL deassert the cycle after a handshake unless a new window is loaded in the same cycle (back-to-back throughput of one window per cycle).
REQ-023 The window SHALL not mix columns across a line wrap: a window is only emitted once col>=2 on the current line.

Reset
REQ-024 On rst, out_valid, out_last, row and column counters SHALL clear to 0; kernel SHALL clear to 0.
REQ-025 Line buffer contents need not be cleared; the row counter gating SHALL make stale data unobservable.
REQ-026 rst mid-frame SHALL discard the partial frame and the next accepted pixel SHALL be treated as (0,0); in_ready SHALL be 1 the cycle after reset.

Configuration
REQ-027 With macro KWIN_LAST_EN defined, out_last SHALL be 1 together with out_valid for the window ending at (IMG_HEIGHT-1, IMG_WIDTH-1), else 0.
REQ-028 Without KWIN_LAST_EN, out_last SHALL be tied to 0 and no last-detect logic SHALL be built.

Verification
REQ-029 IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15, out_ready=1 -> exactly 4 windows; first = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}.
REQ-030 Same stream with out_ready low for 5 cycles at first window -> kernel and out_valid stable, in_ready=0, no pixel lost; window sequence identical.
REQ-031 Two back-to-back 4x4 frames (second 100..115) -> 8 windows; frame-2 first window = {100,101,102,104,105,106,108,109,110}, no mixing with frame 1.
REQ-032 KWIN_LAST_EN defined, 4x4 frame -> out_last=1 only on the 4th window; undefined -> out_last always 0.
REQ-033 rst asserted after 7 pixels of a 4x4 frame, then full frame 0..15 -> output identical to REQ-029.
REQ-034 Random in_valid/out_ready gaps, 64x48 frame of $random pixels -> 2852 windows, each matching a software 3x3 reference model.
